// File: rtl/reg_file_sync_clear_if.sv
// Bus bundle for the sync-clear register file: one write port, two read ports, written flags.
// Latency: none (wiring only); read data/valid are driven from flops in the register file.
// Backpressure: none; reads and writes are accepted every cycle they are enabled.
interface reg_file_sync_clear_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             re_a;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] rdata_a;
    logic             rvalid_a;
    logic             re_b;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_b;
    logic             rvalid_b;
    logic [DEPTH-1:0] written;

    // Requester side: issues writes and read requests, consumes read data.
    modport master (
        output we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        input  rdata_a, rvalid_a, rdata_b, rvalid_b, written
    );

    // Register file side.
    modport slave (
        input  we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
        output rdata_a, rvalid_a, rdata_b, rvalid_b, written
    );
endinterface

// File: rtl/reg_file_sync_clear.sv
// Register file, 1 write + 2 registered read ports, write-first bypass, reg 0 reads as zero.
// Latency: 1 cycle from read enable to rdata/rvalid; writes visible to reads in the same cycle.
// Backpressure: none; every enabled read/write is serviced, synchronous clear overrides both.
module reg_file_sync_clear #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clock,
    input  logic                  clearb,
    reg_file_sync_clear_if.slave  bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;
    logic             rvalid_a_q;
    logic             rvalid_b_q;
    logic [DEPTH-1:0] written_q;

    logic             wr_en;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Writes to address 0 are dropped so register 0 never holds anything but zero.
    assign wr_en = bus.we && (bus.waddr != '0);

    // Next read value per port: zero for address 0, new write data on an address match, else storage.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (bus.raddr_a != '0) begin
            rd_a = (wr_en && (bus.waddr == bus.raddr_a)) ? bus.wdata : mem[bus.raddr_a];
        end
        if (bus.raddr_b != '0) begin
            rd_b = (wr_en && (bus.waddr == bus.raddr_b)) ? bus.wdata : mem[bus.raddr_b];
        end
    end

    // Storage, written flags and read registers; clear wins over any write or read that cycle.
    always_ff @(posedge clock) begin
        if (!clearb) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            written_q  <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[bus.waddr]       <= bus.wdata;
                written_q[bus.waddr] <= 1'b1;
            end
            rvalid_a_q <= bus.re_a;
            rvalid_b_q <= bus.re_b;
            if (bus.re_a) begin
                rdata_a_q <= rd_a;
            end
            if (bus.re_b) begin
                rdata_b_q <= rd_b;
            end
        end
    end

    assign bus.rdata_a  = rdata_a_q;
    assign bus.rvalid_a = rvalid_a_q;
    assign bus.rdata_b  = rdata_b_q;
    assign bus.rvalid_b = rvalid_b_q;
    assign bus.written  = written_q;

endmodule
